data_transposer: RTL and testbench
==================================

DATA_TRANSPOSER -- requirements
Module: data_transposer

Interface
REQ-001 SHALL have parameter WORD_W, default 128, meaning input/output word width in bits.
REQ-002 SHALL have parameter ELEM_W, default 8, meaning transposed element width; WORD_W % ELEM_W == 0.
REQ-003 SHALL have parameter ROWS, default 8, meaning rows per block; ROWS*ELEM_W <= WORD_W.
REQ-004 SHALL define derived constant ELEMS = WORD_W/ELEM_W (default 16) and CH_W = clog2(ELEMS+1).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port channel  input  CH_W  number of output columns per block (1..ELEMS).
REQ-008 SHALL have port DI_valid  input  1  input row valid.
REQ-009 SHALL have port DI_ready  output  1  block can accept a row.
REQ-010 SHALL have port DI  input  WORD_W  input row.
REQ-011 SHALL have port DO_valid  output  1  output column valid.
REQ-012 SHALL have port DO_ready  input  1  downstream accepts column.
REQ-013 SHALL have port DO  output  WORD_W  transposed column.
REQ-014 SHALL have port DO_last  output  1  marks final column of a block.
REQ-015 SHALL have port busy  output  1  high whenever state is not FILL with zero rows buffered.

Function
REQ-016 SHALL implement two states: FILL and DRAIN.
REQ-017 FILL: DI_ready=1; each cycle with DI_valid&DI_ready SHALL store DI into row buffer[row_cnt], row_cnt increments.
REQ-018 channel SHALL be latched on the first row accepted of each block; channel changes mid-block SHALL have no effect.
REQ-019 Latched channel==0 or >ELEMS SHALL be treated as ELEMS.
REQ-020 On acceptance of row ROWS-1: row_cnt->0, col_cnt->0, state->DRAIN, DO_valid=1 on the next cycle (1-cycle latency).
REQ-021 DRAIN: DI_ready=0; no input accepted.
REQ-022 Element e of a row SHALL be bits [WORD_W-1-e*ELEM_W -: ELEM_W] (element 0 at MSB).
REQ-023 Column k SHALL be DO = {row0.elem k, row1.elem k, ..., row(ROWS-1).elem k, zeros}, row0 at MSB, low WORD_W-ROWS*ELEM_W bits zero.
REQ-024 DO, DO_valid, DO_last SHALL be registered; DO/DO_last SHALL hold stable while DO_valid&!DO_ready.
REQ-025 Each DO_valid&DO_ready SHALL advance col_cnt; DO_last=1 exactly when col_cnt == channel_latched-1.
REQ-026 Handshake of the last column SHALL return state to FILL, DO_valid=0 next cycle, DI_ready=1 next cycle.
REQ-027 Columns channel_latched..ELEMS-1 SHALL never be output.
REQ-028 DI_valid during DRAIN SHALL be ignored and not stored.
REQ-029 DO_valid SHALL never deassert without a handshake.

Reset
REQ-030 While rst=0: state=FILL, row_cnt=0, col_cnt=0, DO_valid=0, DO_last=0, DO=0, DI_ready=0 during reset then 1 after release, busy=0, buffers cleared to 0.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL discard partial block; no column of it emitted after release.

Verification
REQ-032 Row r = bytes {r*16+0 .. r*16+15} MSB-first, channel=16, DO_ready=1 -> 16 columns, column k = {k, 16+k, ..., 112+k, 64'd0}, DO_last on 16th, first DO_valid one cycle after 8th row.
REQ-033 channel=3 -> exactly 3 columns, DO_last on third, DI_ready=1 the cycle after.
REQ-034 DO_ready toggled 1/0 per cycle -> DO stable across stall cycles, same 16 values in order, no drops/duplicates.
REQ-035 channel changed 16->2 after first row accepted -> block still outputs 16 columns; channel=0 -> 16 columns.
REQ-036 DI_valid held high during DRAIN with distinct data -> next block contains only rows accepted after DI_ready returns.
REQ-037 rst pulsed after 4 rows accepted -> outputs at reset values; next 8 rows yield columns from those rows only.

Source files
------------

// File: rtl/data_transposer.sv
// Block transposer: buffers ROWS input rows, then emits up to ELEMS columns,
// where column k gathers element k of every buffered row (row 0 at the MSB).
module data_transposer #(
  parameter int WORD_W = 128,
  parameter int ELEM_W = 8,
  parameter int ROWS   = 8,
  localparam int ELEMS = WORD_W / ELEM_W,
  localparam int CH_W  = $clog2(ELEMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   channel,
  input  logic              DI_valid,
  output logic              DI_ready,
  input  logic [WORD_W-1:0] DI,
  output logic              DO_valid,
  input  logic              DO_ready,
  output logic [WORD_W-1:0] DO,
  output logic              DO_last,
  output logic              busy,
  output logic              state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a raised DO_valid stays high, with DO/DO_last frozen, until that
  // transfer happens. DI_ready depends only on state, never on DI_valid.

  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WORD_W-1:0] row_buf [ROWS];
  logic [RC_W-1:0]   row_cnt;
  logic [CH_W-1:0]   col_cnt;
  logic [CH_W-1:0]   col_inc;
  logic [CH_W-1:0]   col_sel;
  logic [CH_W-1:0]   ch_lat;
  logic [CH_W-1:0]   ch_eff;
  logic [CH_W-1:0]   ch_blk;
  logic [WORD_W-1:0] col_next;
  logic              di_fire;
  logic              row_last;
  logic              start_drain;
  logic              do_fire;
  logic              end_drain;

  assign di_fire     = DI_valid & DI_ready;
  assign row_last    = (row_cnt == RC_W'(ROWS - 1));
  assign start_drain = di_fire & row_last;
  assign do_fire     = DO_valid & DO_ready;
  assign end_drain   = do_fire & DO_last;
  assign state_dbg   = state_q;

  // Out-of-range column counts fall back to a full-width block.
  assign ch_eff  = (channel == '0 || channel > CH_W'(ELEMS)) ? CH_W'(ELEMS) : channel;
  // A one-row block latches and finishes in the same cycle.
  assign ch_blk  = (row_cnt == '0) ? ch_eff : ch_lat;
  assign col_inc = col_cnt + CH_W'(1);
  assign col_sel = (state_q == FILL) ? '0 : col_inc;

  // Column gather; while filling, the final row is taken straight from DI so
  // column 0 is ready on the cycle the block completes.
  always_comb begin
    logic [WORD_W-1:0] row_view;
    logic [WORD_W-1:0] shifted;
    col_next = '0;
    row_view = '0;
    shifted  = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_view = (state_q == FILL && r == ROWS - 1) ? DI : row_buf[r];
      shifted  = row_view << (int'(col_sel) * ELEM_W);
      col_next[WORD_W-1-r*ELEM_W -: ELEM_W] = shifted[WORD_W-1 -: ELEM_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    DI_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      FILL: begin
        DI_ready = rst;
        busy     = (row_cnt != '0);
        if (start_drain) state_d = DRAIN;
      end
      DRAIN: begin
        if (end_drain) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt  <= '0;
      col_cnt  <= '0;
      ch_lat   <= CH_W'(ELEMS);
      DO_valid <= 1'b0;
      DO_last  <= 1'b0;
      DO       <= '0;
      for (int r = 0; r < ROWS; r++) row_buf[r] <= '0;
    end else begin
      if (di_fire) begin
        row_buf[row_cnt] <= DI;
        if (row_cnt == '0) ch_lat <= ch_eff;
        row_cnt <= row_last ? '0 : row_cnt + RC_W'(1);
      end
      if (start_drain) begin
        col_cnt  <= '0;
        DO_valid <= 1'b1;
        DO       <= col_next;
        DO_last  <= (ch_blk == CH_W'(1));
      end else if (do_fire) begin
        if (DO_last) begin
          col_cnt  <= '0;
          DO_valid <= 1'b0;
          DO_last  <= 1'b0;
        end else begin
          col_cnt <= col_inc;
          DO      <= col_next;
          DO_last <= (col_inc == ch_lat - CH_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_data_transposer.sv
// Bench for data_transposer: directed blocks plus randomized traffic, checked
// against a row/column reference model and an expected-column queue.
module tb_data_transposer;

  localparam int WORD_W = 128;
  localparam int ELEM_W = 8;
  localparam int ROWS   = 8;
  localparam int ELEMS  = WORD_W / ELEM_W;
  localparam int CH_W   = $clog2(ELEMS + 1);
  localparam logic [WORD_W-1:0] EMASK = {{(WORD_W-ELEM_W){1'b0}}, {ELEM_W{1'b1}}};

  typedef logic [WORD_W:0] w_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH_W-1:0]   channel;
  logic              DI_valid;
  logic              DI_ready;
  logic [WORD_W-1:0] DI;
  logic              DO_valid;
  logic              DO_ready;
  logic [WORD_W-1:0] DO;
  logic              DO_last;
  logic              busy;
  logic              state_dbg;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  logic [WORD_W:0]   exp_q[$];
  logic [WORD_W-1:0] model_rows [ROWS];
  int model_cnt = 0;
  int model_ch  = ELEMS;

  data_transposer #(.WORD_W(WORD_W), .ELEM_W(ELEM_W), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .channel(channel),
    .DI_valid(DI_valid), .DI_ready(DI_ready), .DI(DI),
    .DO_valid(DO_valid), .DO_ready(DO_ready), .DO(DO), .DO_last(DO_last),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string tag, input w_t obs, input w_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_accept(input logic [WORD_W-1:0] data, input int ch);
    logic [WORD_W-1:0] col;
    logic [WORD_W-1:0] elem;
    if (model_cnt == 0) model_ch = (ch == 0 || ch > ELEMS) ? ELEMS : ch;
    model_rows[model_cnt] = data;
    model_cnt++;
    if (model_cnt == ROWS) begin
      for (int k = 0; k < model_ch; k++) begin
        col = '0;
        for (int r = 0; r < ROWS; r++) begin
          elem = (model_rows[r] >> (WORD_W - (k + 1) * ELEM_W)) & EMASK;
          col  = col | (elem << (WORD_W - (r + 1) * ELEM_W));
        end
        exp_q.push_back({(k == model_ch - 1) ? 1'b1 : 1'b0, col});
      end
      model_cnt = 0;
    end
  endtask

  function automatic logic [WORD_W-1:0] seq_row(input int r);
    logic [WORD_W-1:0] d;
    d = '0;
    for (int e = 0; e < ELEMS; e++) d = (d << ELEM_W) | (WORD_W'(r * ELEMS + e) & EMASK);
    return d;
  endfunction

  function automatic logic [WORD_W-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks (start/end just after a rising edge) ----------------
  task automatic idle(input int n);
    DI_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input logic [WORD_W-1:0] data, input int ch);
    bit done;
    done     = 1'b0;
    DI_valid = 1'b1;
    DI       = data;
    channel  = CH_W'(ch);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (DI_ready === 1'b1) begin
        model_accept(data, ch);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    DI_valid = 1'b0;
    if (!done) chk("row_accept_timeout", w_t'(done), w_t'(1));
  endtask

  task automatic send_block(input int ch0, input int chr, input bit seq, input bit lat_chk,
                            input int max_gap);
    for (int r = 0; r < ROWS; r++) begin
      send_row(seq ? seq_row(r) : rand_row(), (r == 0) ? ch0 : chr);
      if (r != ROWS - 1) idle(int'($urandom_range(0, max_gap)));
    end
    if (lat_chk) begin
      @(negedge clk);
      chk("first_col_latency", w_t'(DO_valid), w_t'(1));
      chk("busy_in_drain", w_t'(busy), w_t'(1));
      chk("state_in_drain", w_t'(state_dbg), w_t'(1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic junk_in_drain(input int n);
    for (int i = 0; i < n; i++) begin
      DI_valid = 1'b1;
      DI       = rand_row();
      channel  = CH_W'($urandom_range(0, 31));
      @(negedge clk);
      chk("di_ready_in_drain", w_t'(DI_ready), w_t'(0));
      @(posedge clk);
      #1;
    end
    DI_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || DO_valid !== 1'b0) && i < 3000) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_complete", w_t'(exp_q.size()), w_t'(0));
  endtask

  task automatic do_reset();
    DI_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_do_valid", w_t'(DO_valid), w_t'(0));
    chk("rst_do_last", w_t'(DO_last), w_t'(0));
    chk("rst_do", w_t'(DO), w_t'(0));
    chk("rst_di_ready", w_t'(DI_ready), w_t'(0));
    chk("rst_busy", w_t'(busy), w_t'(0));
    chk("rst_state", w_t'(state_dbg), w_t'(0));
    model_cnt = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_di_ready", w_t'(DI_ready), w_t'(1));
    chk("post_rst_busy", w_t'(busy), w_t'(0));
    chk("post_rst_do_valid", w_t'(DO_valid), w_t'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- downstream ready pattern ----------------
  initial begin
    DO_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       DO_ready = 1'b1;
        1:       DO_ready = ~DO_ready;
        2:       DO_ready = 1'($urandom_range(0, 1));
        default: DO_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard / output monitor ----------------
  initial begin
    logic [WORD_W:0] held;
    logic [WORD_W:0] exp;
    bit stalled;
    bit last_done;
    held      = '0;
    stalled   = 1'b0;
    last_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        stalled   = 1'b0;
        last_done = 1'b0;
      end else begin
        if (last_done) begin
          chk("di_ready_after_last", w_t'(DI_ready), w_t'(1));
          chk("do_valid_after_last", w_t'(DO_valid), w_t'(0));
        end
        if (stalled) begin
          chk("stall_valid_held", w_t'(DO_valid), w_t'(1));
          chk("stall_data_held", {DO_last, DO}, held);
        end
        stalled   = 1'b0;
        last_done = 1'b0;
        if (DO_valid === 1'b1 && DO_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("column_expected", w_t'(exp_q.size()), w_t'(1));
          end else begin
            exp = exp_q.pop_front();
            chk("column", {DO_last, DO}, exp);
          end
          last_done = DO_last;
        end else if (DO_valid === 1'b1) begin
          stalled = 1'b1;
          held    = {DO_last, DO};
        end
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst      = 1'b1;
    DI_valid = 1'b0;
    DI       = '0;
    channel  = CH_W'(ELEMS);
    #2;
    do_reset();

    // Counting-byte block, full width, then junk offered while draining,
    // then a 3-column block whose rows wait for the drain to finish.
    rdy_mode = 0;
    send_block(16, 16, 1'b1, 1'b1, 0);
    junk_in_drain(6);
    send_block(3, 3, 1'b0, 1'b0, 0);
    wait_idle();

    // Alternating downstream stalls.
    rdy_mode = 1;
    send_block(16, 16, 1'b0, 1'b1, 0);
    wait_idle();

    // Channel latched on first row only; zero and oversized counts mean full width.
    rdy_mode = 0;
    send_block(16, 2, 1'b0, 1'b1, 1);
    wait_idle();
    send_block(0, 0, 1'b0, 1'b1, 1);
    wait_idle();
    send_block(20, 5, 1'b0, 1'b1, 1);
    wait_idle();
    send_block(1, 16, 1'b0, 1'b1, 1);
    wait_idle();

    // Reset after a partial block.
    for (int r = 0; r < 4; r++) send_row(rand_row(), 16);
    @(negedge clk);
    chk("busy_partial", w_t'(busy), w_t'(1));
    @(posedge clk);
    #1;
    do_reset();
    send_block(16, 16, 1'b0, 1'b1, 0);
    wait_idle();

    // Reset while a block is stalled mid-drain.
    rdy_mode = 3;
    send_block(16, 16, 1'b0, 1'b1, 0);
    idle(3);
    @(negedge clk);
    chk("drain_stalled", w_t'(DO_valid), w_t'(1));
    @(posedge clk);
    #1;
    do_reset();
    rdy_mode = 0;
    idle(20);
    chk("no_column_after_rst", w_t'(DO_valid), w_t'(0));

    // Randomized traffic.
    rdy_mode = 2;
    for (int b = 0; b < 24; b++) begin
      send_block(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b0, 1'b0, 2);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 20)));
    end
    wait_idle();
    @(negedge clk);
    chk("final_busy", w_t'(busy), w_t'(0));
    chk("final_di_ready", w_t'(DI_ready), w_t'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
